// File: rtl/imem_loader_if.sv
// Host command stream and instruction-memory write port of the boot loader.
// The master side is the host/memory environment; the slave side is the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [DATA_W-1:0] im_wdata;

  modport master (
    output cmd_valid, cmd_data,
    input  cmd_ready, im_we, im_addr, im_wdata
  );

  modport slave (
    input  cmd_valid, cmd_data,
    output cmd_ready, im_we, im_addr, im_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: writes a framed, XOR-checksummed program into instruction memory,
// releases the core once the checksum matches, and counts cycles until the core is done.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 9,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  imem_loader_if.slave     bus,
  output logic             cpu_reset,
  input  logic             cpu_done,
  output logic             load_done,
  output logic             load_err,
  output logic [CNT_W-1:0] run_cycles
);

  typedef enum logic [2:0] {
    S_HDR,
    S_DATA,
    S_SUM,
    S_RUN,
    S_HALT,
    S_ERR
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] csum;
  logic              fire;
  logic              is_hdr;
  logic              hdr_take;
  logic              data_take;
  logic              released_next;

  assign bus.cmd_ready = (state != S_RUN);
  assign fire          = bus.cmd_valid && bus.cmd_ready;
  assign is_hdr        = bus.cmd_data[DATA_W-1];
  assign data_take     = fire && (state == S_DATA);
  assign released_next = (next_state == S_RUN) || (next_state == S_HALT);

  // A header is honoured from HDR, HALT and ERR alike; elsewhere in HALT/ERR words are dropped.
  always_comb begin
    next_state = state;
    hdr_take   = 1'b0;
    case (state)
      S_HDR: begin
        if (fire) begin
          if (is_hdr) begin
            next_state = S_DATA;
            hdr_take   = 1'b1;
          end else begin
            next_state = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (fire && (idx == last_idx)) next_state = S_SUM;
      end
      S_SUM: begin
        if (fire) next_state = (bus.cmd_data == csum) ? S_RUN : S_ERR;
      end
      S_RUN: begin
        if (cpu_done) next_state = S_HALT;
      end
      S_HALT, S_ERR: begin
        if (fire && is_hdr) begin
          next_state = S_DATA;
          hdr_take   = 1'b1;
        end
      end
      default: next_state = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_HDR;
      last_idx     <= '0;
      idx          <= '0;
      csum         <= '0;
      bus.im_we    <= 1'b0;
      bus.im_addr  <= '0;
      bus.im_wdata <= '0;
      cpu_reset    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      run_cycles   <= '0;
    end else begin
      state     <= next_state;
      bus.im_we <= data_take;
      if (data_take) begin
        bus.im_addr  <= idx;
        bus.im_wdata <= bus.cmd_data;
        idx          <= idx + 1'b1;
        csum         <= csum ^ bus.cmd_data;
      end
      // A new header restarts the frame bookkeeping and the run counter together.
      if (hdr_take) begin
        last_idx   <= bus.cmd_data[ADDR_W-1:0];
        idx        <= '0;
        csum       <= '0;
        run_cycles <= '0;
      end else if ((state == S_RUN) && !cpu_done && (run_cycles != {CNT_W{1'b1}})) begin
        run_cycles <= run_cycles + 1'b1;
      end
      cpu_reset <= !released_next;
      load_done <= released_next;
      load_err  <= (next_state == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: a frame-level model predicts writes
// and load status, and a negedge monitor checks every write against the queue.
module tb_imem_loader;

  typedef struct {
    logic [7:0] addr;
    logic [8:0] data;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        cpu_done;
  logic        cpu_reset;
  logic        load_done;
  logic        load_err;
  logic [15:0] run_cycles;

  imem_loader_if #(.ADDR_W(8), .DATA_W(9)) bus ();

  imem_loader #(.ADDR_W(8), .DATA_W(9), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .cpu_reset (cpu_reset),
    .cpu_done  (cpu_done),
    .load_done (load_done),
    .load_err  (load_err),
    .run_cycles(run_cycles)
  );

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         xfer_cycles = 0;
  int         model_status = 0;  // 0 fresh, 1 released, 2 error
  wr_t        exp_q[$];
  int         wr_cyc[$];
  logic [8:0] frame_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write must match the head of the expected queue.
  always @(negedge clk) begin
    if (reset && bus.im_we) begin
      wr_t e;
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_write actual=addr %0h data %0h required=none", bus.im_addr, bus.im_wdata);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(bus.im_addr), 32'(e.addr));
        checkOutput("wr_data", 32'(bus.im_wdata), 32'(e.data));
      end
    end
  end

  task automatic sendWord(input logic [8:0] w, input bit rand_valid);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      bus.cmd_data  = w;
      bus.cmd_valid = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      acc = bus.cmd_valid && bus.cmd_ready;
      @(posedge clk);
      #1;
      xfer_cycles++;
      guard++;
      if (!acc && guard > 1000) begin
        checkOutput("send_timeout", 32'(guard), 32'd0);
        acc = 1'b1;
      end
    end
  endtask

  // Frame-level reference: a header yields N writes and a pass/fail checksum verdict.
  task automatic applyStimulus(input bit rand_valid);
    logic [8:0] x;
    logic [8:0] hdr;
    int n;
    bit is_frame;
    hdr = frame_q[0];
    is_frame = hdr[8];
    if (is_frame) begin
      n = int'(hdr[7:0]) + 1;
      x = '0;
      for (int i = 1; i <= n; i++) begin
        exp_q.push_back('{addr: 8'(i - 1), data: frame_q[i]});
        x ^= frame_q[i];
      end
      model_status = (frame_q[n + 1] == x) ? 1 : 2;
    end else if (model_status == 0) begin
      model_status = 2;
    end
    xfer_cycles = 0;
    foreach (frame_q[i]) sendWord(frame_q[i], rand_valid);
    bus.cmd_valid = 1'b0;
    checkOutput("cpu_reset", 32'(cpu_reset), 32'(model_status != 1));
    checkOutput("load_done", 32'(load_done), 32'(model_status == 1));
    checkOutput("load_err", 32'(load_err), 32'(model_status == 2));
    if (is_frame) checkOutput("run_cycles_cleared", 32'(run_cycles), 32'd0);
  endtask

  task automatic randomFrame(input int n, input bit good);
    logic [8:0] x;
    logic [8:0] w;
    frame_q.delete();
    frame_q.push_back(9'h100 | 9'(n - 1));
    x = '0;
    for (int i = 0; i < n; i++) begin
      w = 9'($urandom);
      frame_q.push_back(w);
      x ^= w;
    end
    frame_q.push_back(good ? x : (x ^ 9'($urandom_range(1, 511))));
  endtask

  task automatic runCore(input int k);
    cpu_done = 1'b0;
    repeat (k) @(posedge clk);
    #1;
    cpu_done = 1'b1;
    @(posedge clk);
    #1;
    cpu_done = 1'b0;
    checkOutput("run_count", 32'(run_cycles), 32'(k));
    checkOutput("halt_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("run_frozen", 32'(run_cycles), 32'(k));
  endtask

  task automatic checkDrained(input string name);
    repeat (2) @(posedge clk);
    #1;
    checkOutput(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    checkOutput("rst_im_we", 32'(bus.im_we), 32'd0);
    checkOutput("rst_im_addr", 32'(bus.im_addr), 32'd0);
    checkOutput("rst_im_wdata", 32'(bus.im_wdata), 32'd0);
    checkOutput("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst_load_done", 32'(load_done), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    checkOutput("rst_run_cycles", 32'(run_cycles), 32'd0);
    checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    reset = 1'b1;
    model_status = 0;
  endtask

  initial begin
    reset = 1'b0;
    cpu_done = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_data = '0;
    @(posedge clk);
    #1;
    doReset();

    // Directed 3-word frame with valid held high.
    wr_cyc.delete();
    frame_q = '{9'h102, 9'h0A5, 9'h13C, 9'h001, 9'h198};
    applyStimulus(1'b0);
    checkOutput("throughput", 32'(xfer_cycles), 32'd5);
    @(negedge clk);
    #1;
    checkOutput("wr_count", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) checkOutput("wr_back_to_back", 32'(wr_cyc[2] - wr_cyc[0]), 32'd2);
    runCore(10);
    checkDrained("drain_t1");

    // Non-header words in HALT are discarded.
    frame_q = '{9'h055, 9'h0AA};
    applyStimulus(1'b1);
    checkOutput("halt_discard_count", 32'(run_cycles), 32'd10);
    checkDrained("drain_halt");

    // Bad checksum on reload from HALT.
    frame_q = '{9'h102, 9'h0A5, 9'h13C, 9'h001, 9'h000};
    applyStimulus(1'b0);
    checkDrained("drain_badsum");

    // Non-header first word after reset, then a 1-word recovery frame.
    doReset();
    frame_q = '{9'h055};
    applyStimulus(1'b0);
    frame_q = '{9'h100, 9'h0FF, 9'h0FF};
    applyStimulus(1'b0);
    runCore(0);
    checkDrained("drain_t4");

    // Full 256-word frame with random valid gaps, then random frames.
    randomFrame(256, 1'b1);
    applyStimulus(1'b1);
    runCore(int'($urandom_range(1, 30)));
    checkDrained("drain_256");
    randomFrame(int'($urandom_range(1, 40)), 1'b0);
    applyStimulus(1'b1);
    checkDrained("drain_rand_bad");
    randomFrame(int'($urandom_range(1, 40)), 1'b1);
    applyStimulus(1'b1);
    runCore(int'($urandom_range(1, 20)));
    checkDrained("drain_rand_good");

    // Reset while word 5 of a 16-word frame is on the bus.
    sendWord(9'h10F, 1'b0);
    for (int i = 0; i < 5; i++) begin
      logic [8:0] w;
      w = 9'($urandom);
      exp_q.push_back('{addr: 8'(i), data: w});
      sendWord(w, 1'b0);
    end
    bus.cmd_data = 9'h123;
    bus.cmd_valid = 1'b1;
    @(negedge clk);
    #1;
    doReset();
    checkDrained("drain_abort");
    randomFrame(int'($urandom_range(1, 20)), 1'b1);
    applyStimulus(1'b0);
    runCore(int'($urandom_range(1, 10)));
    checkDrained("drain_after_abort");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
